mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the execute stage and the 256 × 32-bit data memory. It accepts one byte, halfword or word access per request over a valid/ready handshake and converts the byte address to the memory's 28-bit word address. Sub-word stores are performed as read-modify-write. Load results are sign- or zero-extended and returned with a register tag on a valid/ready response channel.

## Interface
- No parameters. Widths are fixed: 32-bit data, 32-bit byte address, 28-bit word address, 5-bit tag.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed` in 1: load extension. 1 = sign-extend, 0 = zero-extend. Ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_tag` in 5: destination register tag.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: extended load data; 0 for stores and errors.
- `resp_tag` out 5: tag captured from the request.
- `resp_err` out 1: misaligned access or illegal size.
- `mem_addr` out 28: word address, equal to `req_addr[29:2]` of the latched request.
- `mem_wdata` out 32: write data to memory.
- `mem_wr` out 1: memory write enable.
- `mem_rd` out 1: memory read enable.
- `mem_rdata` in 32: memory read data, valid combinationally in the same cycle `mem_rd` is high.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- `req_ready` = (state == IDLE) and rst high.
- A handshake occurs when `req_valid` and `req_ready` are both high at a rising edge. At the handshake, latch addr, wdata, size, we, signed and tag.
- Error check at the handshake:
  - size 11 is an error.
  - half with `addr[0]` = 1 is an error.
  - word with `addr[1:0]` ≠ 00 is an error.
  - On error: go to RESP with `resp_err` = 1 and `resp_data` = 0. No memory access occurs.
- Routing from the handshake:
  - Load → READ.
  - Word store → WRITE.
  - Byte/half store → READ, then WRITE (read-modify-write).
- READ: `mem_rd` = 1. Capture `mem_rdata` into the word buffer at the edge that leaves READ.
  - Next state is RESP for a load, WRITE for a sub-word store.
- WRITE: `mem_wr` = 1.
  - Word store: `mem_wdata` = wdata.
  - Sub-word store: `mem_wdata` = buffer with the target lane replaced, little-endian.
    - Byte lane = `addr[1:0]`; byte data is `wdata[7:0]`.
    - Half lane = `addr[1]`; half data is `wdata[15:0]`.
    - All other lanes are preserved.
  - Next state is RESP.
- Load extraction (little-endian): byte = `buf[8*addr[1:0] +: 8]`, half = `buf[16*addr[1] +: 16]`. Extend to 32 bits per `req_signed`.
- RESP: `resp_valid` = 1, holding `resp_data`, `resp_tag` and `resp_err` stable until `resp_ready` is high at an edge, then go to IDLE.
- `mem_rd` and `mem_wr` are never high together. Both are low in IDLE and RESP.
- `mem_addr` and `mem_wdata` are 0 outside READ and WRITE.

## Timing
- While `rst` is low:
  - state = IDLE.
  - `req_ready`, `resp_valid`, `resp_err`, `mem_rd` and `mem_wr` are 0.
  - `resp_data`, `resp_tag`, `mem_addr`, `mem_wdata` and the word buffer are 0.
- Reset asserted mid-access (in READ or WRITE): strobes drop immediately and the access is abandoned. No response is ever issued for it.
- Handshake at edge 0; `resp_valid` rises after:
  - Load: edge 2 (READ cycle 1).
  - Word store: edge 2 (WRITE cycle 1).
  - Sub-word store: edge 3 (READ cycle 1, WRITE cycle 2).
  - Error: edge 1.
- Back-to-back: after the response handshake at edge N, `req_ready` is high in cycle N+1. There is no overlap of requests; throughput is at most one access per 3 cycles.
- A response stall of any length holds all response outputs constant. `req_ready` stays 0 during the stall.

## Test plan
- Reset with `rst` = 0 for 3 cycles, then release → all outputs 0 during reset; `req_ready` = 1 on the first cycle after release.
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 → `mem_addr` = 4 and `mem_wr` high for exactly 1 cycle; load returns 0xDEADBEEF with the matching tag at edge 2.
- Word 0x11223344 at addr 0x20, then byte store 0xAA to addr 0x21 → READ then WRITE with `mem_wdata` = 0x1122AA44. Follow with a signed byte load from 0x21 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half load from 0x22 of word 0x8001xxxx → signed 0xFFFF8001, unsigned 0x00008001. Half load from 0x23 → `resp_err` = 1 at edge 1, no `mem_rd` pulse.
- Hold `resp_ready` = 0 for 5 cycles → `resp_valid` and `resp_data` stable and `req_ready` = 0 throughout; one cycle after accept, `req_ready` = 1.
- Assert reset during the READ cycle of a byte store → no `mem_wr` pulse, memory word unchanged, no `resp_valid`; FSM is back in IDLE after reset is released.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer between the execute stage and a 256 x 32-bit data
// memory. Accepts one byte/half/word access per request handshake, maps the
// byte address to a 28-bit word address, performs sub-word stores as
// read-modify-write and returns extended load data with a register tag.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req_*           request channel (valid/ready, we, size, signed, addr,
//                   wdata, tag)
//   resp_*          response channel (valid/ready, data, tag, err)
//   mem_*           memory side (word addr, write data, wr/rd strobes,
//                   combinational read data)
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_tag,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_tag,
   output logic        resp_err,
   output logic [27:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state, state_nxt;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        we_q;
   logic        sgn_q;
   logic [4:0]  tag_q;
   logic        err_q;
   logic [31:0] buf_q;
   logic        req_err;
   logic        hs;
   logic [31:0] merged;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        unused_addr_hi;

   // Upper address bits fall outside the 28-bit word address space.
   assign unused_addr_hi = &{1'b0, req_addr[31:30]};

   assign req_ready = (state == IDLE) && rst;
   assign hs        = req_valid && req_ready;

   // Illegal size or misalignment is detected on the incoming request so the
   // FSM can skip the memory entirely.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         SZ_BYTE: req_err = 1'b0;
         default: req_err = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Request fields are captured only at the handshake so the response stays
   // stable however long the consumer stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         tag_q   <= '0;
         err_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         if (hs) begin
            addr_q  <= req_addr[29:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            sgn_q   <= req_signed;
            tag_q   <= req_tag;
            err_q   <= req_err;
         end
         if (state == READ) buf_q <= mem_rdata;
      end
   end

   // Next-state logic. Word stores skip the read; sub-word stores read the
   // word first so untouched lanes can be written back unchanged.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (hs) begin
               if (req_err)                          state_nxt = RESP;
               else if (req_we && req_size == SZ_WORD) state_nxt = WRITE;
               else                                  state_nxt = READ;
            end
         end
         READ:    state_nxt = we_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lane merge for sub-word stores (little-endian).
   always_comb begin
      merged = buf_q;
      if (size_q == SZ_BYTE)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (size_q == SZ_HALF)
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // Memory side: address and data are forced to zero outside an access.
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == READ) begin
         mem_rd   = 1'b1;
         mem_addr = addr_q[29:2];
      end else if (state == WRITE) begin
         mem_wr    = 1'b1;
         mem_addr  = addr_q[29:2];
         mem_wdata = (size_q == SZ_WORD) ? wdata_q : merged;
      end
   end

   // Response side: load extraction and extension from the word buffer.
   always_comb begin
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_tag   = '0;
      resp_err   = 1'b0;
      ld_byte    = buf_q[{addr_q[1:0], 3'b000} +: 8];
      ld_half    = buf_q[{addr_q[1], 4'b0000} +: 16];
      if (state == RESP) begin
         resp_valid = 1'b1;
         resp_tag   = tag_q;
         resp_err   = err_q;
         if (!err_q && !we_q) begin
            case (size_q)
               SZ_BYTE: resp_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
               SZ_HALF: resp_data = {{16{sgn_q & ld_half[15]}}, ld_half};
               default: resp_data = buf_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios against a behavioural
// 256-word memory, with hand-computed expected values.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_tag = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;
   logic        resp_err;
   logic [27:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] mem_rdata;

   logic [31:0] mem [256];

   int passed = 0;
   int total  = 0;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .mem_rd(mem_rd), .mem_rdata(mem_rdata)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Behavioural data memory with combinational read.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
   end

   // Issues one request, waits for its response and accepts it. lat counts
   // rising edges from the handshake edge (inclusive) until resp_valid is seen.
   task automatic run_req(input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] tag,
                          output int lat, output logic [31:0] data,
                          output logic err, output logic [4:0] tag_o,
                          output int wr_cnt, output int rd_cnt,
                          output logic [27:0] last_addr,
                          output logic [31:0] last_wdata);
      lat = 0; wr_cnt = 0; rd_cnt = 0;
      data = '0; err = 1'b0; tag_o = '0; last_addr = '0; last_wdata = '0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata; req_tag = tag;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_wr) begin
            wr_cnt++;
            last_addr = mem_addr;
            last_wdata = mem_wdata;
         end
         if (mem_rd) begin
            rd_cnt++;
            last_addr = mem_addr;
         end
         if (resp_valid) break;
         @(posedge clk);
         lat++;
      end
      data = resp_data; err = resp_err; tag_o = resp_tag;
      if (!resp_valid) lat = -1;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({req_ready, resp_valid, resp_err, mem_rd, mem_wr} !== 5'b0) begin
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {req_ready, resp_valid, resp_err, mem_rd, mem_wr});
         end else passed++;
         total++;
         if ({resp_data, resp_tag, mem_addr, mem_wdata} !== '0) begin
            $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected zeros",
                     resp_data, resp_tag, mem_addr, mem_wdata);
         end else passed++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
      else passed++;
   endtask

   task automatic test_word();
      int lat, wrc, rdc;
      logic [31:0] d, lw;
      logic e;
      logic [4:0] t;
      logic [27:0] la;
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (lat !== 2) $display("[TB] FAIL wstore_latency: got %0d expected 2", lat); else passed++;
      total++;
      if (wrc !== 1 || rdc !== 0) $display("[TB] FAIL wstore_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wrc, rdc); else passed++;
      total++;
      if (la !== 28'd4 || lw !== 32'hDEADBEEF) $display("[TB] FAIL wstore_mem: got addr=%h data=%h expected 4/deadbeef", la, lw); else passed++;
      total++;
      if (d !== 32'h0 || e !== 1'b0 || t !== 5'd3) $display("[TB] FAIL wstore_resp: got data=%h err=%b tag=%0d expected 0/0/3", d, e, t); else passed++;
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (lat !== 2 || rdc !== 1 || wrc !== 0) $display("[TB] FAIL wload_timing: got lat=%0d rd=%0d wr=%0d expected 2/1/0", lat, rdc, wrc); else passed++;
      total++;
      if (d !== 32'hDEADBEEF || t !== 5'd7 || e !== 1'b0) $display("[TB] FAIL wload_resp: got data=%h tag=%0d err=%b expected deadbeef/7/0", d, t, e); else passed++;
   endtask

   task automatic test_byte_rmw();
      int lat, wrc, rdc;
      logic [31:0] d, lw;
      logic e;
      logic [4:0] t;
      logic [27:0] la;
      run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd1, lat, d, e, t, wrc, rdc, la, lw);
      run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, 5'd2, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (lat !== 3 || rdc !== 1 || wrc !== 1) $display("[TB] FAIL bstore_timing: got lat=%0d rd=%0d wr=%0d expected 3/1/1", lat, rdc, wrc); else passed++;
      total++;
      if (lw !== 32'h1122AA44 || la !== 28'd8) $display("[TB] FAIL bstore_wdata: got %h@%h expected 1122aa44@8", lw, la); else passed++;
      total++;
      if (mem[8] !== 32'h1122AA44) $display("[TB] FAIL bstore_memword: got %h expected 1122aa44", mem[8]); else passed++;
      run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 5'd4, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (d !== 32'hFFFFFFAA || lat !== 2) $display("[TB] FAIL bload_signed: got %h lat=%0d expected ffffffaa lat=2", d, lat); else passed++;
      run_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 5'd5, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (d !== 32'h000000AA) $display("[TB] FAIL bload_unsigned: got %h expected 000000aa", d); else passed++;
      run_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 5'd5, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (d !== 32'h00000011) $display("[TB] FAIL bload_lane3: got %h expected 00000011", d); else passed++;
   endtask

   task automatic test_half();
      int lat, wrc, rdc;
      logic [31:0] d, lw;
      logic e;
      logic [4:0] t;
      logic [27:0] la;
      run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80011234, 5'd1, lat, d, e, t, wrc, rdc, la, lw);
      run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 5'd9, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (d !== 32'hFFFF8001 || t !== 5'd9) $display("[TB] FAIL hload_signed: got %h tag=%0d expected ffff8001 tag=9", d, t); else passed++;
      run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 5'd9, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (d !== 32'h00008001) $display("[TB] FAIL hload_unsigned: got %h expected 00008001", d); else passed++;
      run_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 5'd10, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (e !== 1'b1 || lat !== 1 || rdc !== 0 || d !== 32'h0 || t !== 5'd10)
         $display("[TB] FAIL hload_misaligned: got err=%b lat=%0d rd=%0d data=%h tag=%0d expected 1/1/0/0/10", e, lat, rdc, d, t);
      else passed++;
      run_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555, 5'd11, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (e !== 1'b1 || wrc !== 0 || mem[8] !== 32'h80011234) $display("[TB] FAIL wstore_misaligned: got err=%b wr=%0d mem=%h expected 1/0/80011234", e, wrc, mem[8]); else passed++;
      run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 5'd12, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (e !== 1'b1 || rdc !== 0 || lat !== 1) $display("[TB] FAIL illegal_size: got err=%b rd=%0d lat=%0d expected 1/0/1", e, rdc, lat); else passed++;
      run_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFFBEEF, 5'd13, lat, d, e, t, wrc, rdc, la, lw);
      total++;
      if (lw !== 32'h8001BEEF || lat !== 3 || mem[8] !== 32'h8001BEEF) $display("[TB] FAIL hstore_rmw: got %h lat=%0d mem=%h expected 8001beef/3/8001beef", lw, lat, mem[8]); else passed++;
   endtask

   task automatic test_stall();
      int bad = 0;
      bool_wait: begin end
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h10; req_tag = 5'd21;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_tag !== 5'd21 || req_ready !== 1'b0) bad++;
      end
      total++;
      if (bad !== 0) $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad); else passed++;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("[TB] FAIL stall_release: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); else passed++;
   endtask

   task automatic test_reset_mid();
      int lat, wrc, rdc, seen;
      logic [31:0] d, lw;
      logic e;
      logic [4:0] t;
      logic [27:0] la;
      run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 5'd1, lat, d, e, t, wrc, rdc, la, lw);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h31;
      req_wdata = 32'h000000EE; req_tag = 5'd2;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b1) $display("[TB] FAIL midreset_in_read: got mem_rd=%b expected 1", mem_rd); else passed++;
      rst = 1'b0;
      #1;
      total++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0) $display("[TB] FAIL midreset_strobes: got rd=%b wr=%b expected 0/0", mem_rd, mem_wr); else passed++;
      seen = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (mem_wr || resp_valid) seen++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_wr || resp_valid) seen++;
      end
      total++;
      if (seen !== 0) $display("[TB] FAIL midreset_no_activity: got %0d cycles with wr/resp expected 0", seen); else passed++;
      total++;
      if (req_ready !== 1'b1) $display("[TB] FAIL midreset_idle: got req_ready=%b expected 1", req_ready); else passed++;
      total++;
      if (mem[12] !== 32'hCAFEF00D) $display("[TB] FAIL midreset_mem: got %h expected cafef00d", mem[12]); else passed++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_word();
      test_byte_rmw();
      test_half();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
